// File: rtl/lif_pkg.sv
// Shared config addresses and the saturating leak/integrate step for the LIF neuron array.
// Pure combinational helpers; no storage and no flow control.
package lif_pkg;

    localparam logic [1:0] CFG_THRESH  = 2'd0;
    localparam logic [1:0] CFG_LEAK    = 2'd1;
    localparam logic [1:0] CFG_REFRACT = 2'd2;
    localparam logic [1:0] CFG_MASK    = 2'd3;

    localparam int LIF_MAX_W = 32;

    // st - (st >> leak) + cur, evaluated one bit wider than the operands and
    // clamped to the all-ones value of a w-bit membrane (w < LIF_MAX_W).
    function automatic logic [LIF_MAX_W-1:0] lif_next(
        input logic [LIF_MAX_W-1:0] st,
        input logic [LIF_MAX_W-1:0] cur,
        input logic [2:0]           leak,
        input int                   w
    );
        logic [LIF_MAX_W:0] sum;
        logic [LIF_MAX_W:0] sat;
        sum = {1'b0, st} - {1'b0, (st >> leak)} + {1'b0, cur};
        sat = {(LIF_MAX_W+1){1'b1}} >> (LIF_MAX_W + 1 - w);
        return (sum > sat) ? sat[LIF_MAX_W-1:0] : sum[LIF_MAX_W-1:0];
    endfunction

endpackage

// File: rtl/lif_cell.sv
// One LIF neuron: membrane, refractory counter and spike register; state/spike valid one edge after inputs.
// No backpressure; 'fire' is the combinational spike decision for the coming edge.
module lif_cell
    import lif_pkg::*;
#(
    parameter int W  = 8,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          step,
    input  logic [W-1:0]  current,
    input  logic [W-1:0]  threshold,
    input  logic [2:0]    leak,
    input  logic [RW-1:0] refract,
    output logic [W-1:0]  state,
    output logic          spike,
    output logic          fire
);

    logic [RW-1:0]        refr;
    logic [LIF_MAX_W-1:0] nxt_full;

    assign nxt_full = lif_next(LIF_MAX_W'(state), LIF_MAX_W'(current), leak, W);
    assign fire     = step && (refr == '0) && (nxt_full >= LIF_MAX_W'(threshold));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= '0;
            refr  <= '0;
            spike <= 1'b0;
        end else begin
            spike <= 1'b0;
            if (step) begin
                if (refr != '0) begin
                    // refractory: current ignored, membrane pinned at rest
                    refr  <= refr - 1'b1;
                    state <= '0;
                end else if (fire) begin
                    spike <= 1'b1;
                    state <= '0;
                    refr  <= refract;
                end else begin
                    state <= nxt_full[W-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/lif_array.sv
// N_CH LIF neurons with shared config regs and a priority-encoded spike event stream; one-edge latency.
// Events wait in per-channel pending bits while evt_ready is low; a respike onto a pending bit sets sticky overflow.
module lif_array
    import lif_pkg::*;
#(
    parameter int N_CH            = 4,
    parameter int W               = 8,
    parameter int RW              = 4,
    parameter int THRESH_DEFAULT  = 200,
    parameter int LEAK_DEFAULT    = 2,
    parameter int REFRACT_DEFAULT = 3,
    localparam int IDW            = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [N_CH*W-1:0] current,
    input  logic              cfg_we,
    input  logic [1:0]        cfg_addr,
    input  logic [W-1:0]      cfg_data,
    output logic [N_CH*W-1:0] state,
    output logic [N_CH-1:0]   spike,
    output logic              evt_valid,
    output logic [IDW-1:0]    evt_id,
    input  logic              evt_ready,
    output logic              overflow
);

    logic [W-1:0]    threshold;
    logic [2:0]      leak;
    logic [RW-1:0]   refract;
    logic [N_CH-1:0] ch_en;
    logic [N_CH-1:0] fire;
    logic [N_CH-1:0] pending;
    logic [N_CH-1:0] clr;

    always_ff @(posedge clk) begin
        if (rst) begin
            threshold <= W'(THRESH_DEFAULT);
            leak      <= 3'(LEAK_DEFAULT);
            refract   <= RW'(REFRACT_DEFAULT);
            ch_en     <= '1;
        end else if (cfg_we) begin
            case (cfg_addr)
                CFG_THRESH:  threshold <= cfg_data;
                CFG_LEAK:    leak      <= cfg_data[2:0];
                CFG_REFRACT: refract   <= cfg_data[RW-1:0];
                CFG_MASK:    ch_en     <= cfg_data[N_CH-1:0];
            endcase
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_cell
        lif_cell #(
            .W  (W),
            .RW (RW)
        ) u_cell (
            .clk       (clk),
            .rst       (rst),
            .step      (en && ch_en[i]),
            .current   (current[i*W +: W]),
            .threshold (threshold),
            .leak      (leak),
            .refract   (refract),
            .state     (state[i*W +: W]),
            .spike     (spike[i]),
            .fire      (fire[i])
        );
    end

    assign evt_valid = |pending;

    // fixed priority: lowest pending channel is presented
    always_comb begin
        evt_id = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (pending[i]) evt_id = IDW'(i);
        end
    end

    always_comb begin
        clr = '0;
        for (int i = 0; i < N_CH; i++) begin
            clr[i] = evt_valid && evt_ready && (evt_id == IDW'(i));
        end
    end

    // a spike landing on the same edge its old event is accepted just re-arms the bit
    always_ff @(posedge clk) begin
        if (rst) begin
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            pending <= fire | (pending & ~clr);
            if (|(fire & pending & ~clr)) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_lif_array.sv
// Directed bench for lif_array: expectations are queued as stimulus is driven and checked after each edge.
module tb_lif_array;

    localparam int N_CH = 4;
    localparam int W    = 8;

    localparam int K_STATE = 0;
    localparam int K_SPIKE = 1;
    localparam int K_VALID = 2;
    localparam int K_ID    = 3;
    localparam int K_OVF   = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic [N_CH*W-1:0] current;
    logic              cfg_we;
    logic [1:0]        cfg_addr;
    logic [W-1:0]      cfg_data;
    logic [N_CH*W-1:0] state;
    logic [N_CH-1:0]   spike;
    logic              evt_valid;
    logic [1:0]        evt_id;
    logic              evt_ready;
    logic              overflow;

    typedef struct {
        string       tag;
        int          kind;
        int          ch;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    lif_array dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .current   (current),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_data  (cfg_data),
        .state     (state),
        .spike     (spike),
        .evt_valid (evt_valid),
        .evt_id    (evt_id),
        .evt_ready (evt_ready),
        .overflow  (overflow)
    );

    function automatic logic [31:0] observe(input int kind, input int ch);
        case (kind)
            K_STATE: return 32'(state[ch*W +: W]);
            K_SPIKE: return 32'(spike[ch]);
            K_VALID: return 32'(evt_valid);
            K_ID:    return 32'(evt_id);
            default: return 32'(overflow);
        endcase
    endfunction

    task automatic expect_val(input string tag, input int kind, input int ch, input int val);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.ch   = ch;
        e.val  = 32'(val);
        exp_q.push_back(e);
    endtask

    task automatic expect_idle(input string tag);
        for (int c = 0; c < N_CH; c++) begin
            expect_val(tag, K_STATE, c, 0);
            expect_val(tag, K_SPIKE, c, 0);
        end
        expect_val(tag, K_VALID, 0, 0);
        expect_val(tag, K_ID, 0, 0);
        expect_val(tag, K_OVF, 0, 0);
    endtask

    // one clock edge, then retire every expectation queued for it
    task automatic tick();
        exp_t        e;
        logic [31:0] obs;
        @(posedge clk);
        #1;
        while (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            obs = observe(e.kind, e.ch);
            checks++;
            assert (obs === e.val)
            else begin
                errors++;
                $error("FAIL %s kind=%0d ch=%0d observed=%0d expected=%0d", e.tag, e.kind, e.ch, obs, e.val);
            end
        end
    endtask

    task automatic set_cur(input int ch, input int val);
        current[ch*W +: W] = W'(val);
    endtask

    task automatic cfg_write(input logic [1:0] addr, input int data);
        cfg_we   = 1'b1;
        cfg_addr = addr;
        cfg_data = W'(data);
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        en  = 1'b0;
        current = '0;
        expect_idle(tag);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int seq1[11];
        seq1 = '{60, 105, 139, 165, 184, 198, 0, 0, 0, 0, 60};

        rst = 1'b1; en = 1'b0; current = '0; cfg_we = 1'b0;
        cfg_addr = '0; cfg_data = '0; evt_ready = 1'b0;
        tick();
        do_reset("reset");

        // default config integration, spike on 7th step, 3-step refractory
        en = 1'b1; evt_ready = 1'b1; set_cur(0, 60);
        for (int s = 0; s < 11; s++) begin
            expect_val($sformatf("int_state%0d", s), K_STATE, 0, seq1[s]);
            expect_val($sformatf("int_spike%0d", s), K_SPIKE, 0, (s == 6) ? 1 : 0);
            if (s == 6) begin
                expect_val("int_evt_valid", K_VALID, 0, 1);
                expect_val("int_evt_id", K_ID, 0, 0);
            end
            tick();
        end

        // saturation
        do_reset("rst_sat");
        cfg_write(2'd0, 255);
        cfg_write(2'd1, 7);
        en = 1'b1; set_cur(2, 200);
        expect_val("sat_state1", K_STATE, 2, 200);
        expect_val("sat_spike1", K_SPIKE, 2, 0);
        tick();
        expect_val("sat_spike2", K_SPIKE, 2, 1);
        expect_val("sat_state2", K_STATE, 2, 0);
        tick();

        // simultaneous events on ch1 and ch3, consumer stalls two cycles
        do_reset("rst_evt");
        evt_ready = 1'b0; en = 1'b1; set_cur(1, 250); set_cur(3, 250);
        expect_val("evt_spike1", K_SPIKE, 1, 1);
        expect_val("evt_spike3", K_SPIKE, 3, 1);
        expect_val("evt_valid_a", K_VALID, 0, 1);
        expect_val("evt_id_a", K_ID, 0, 1);
        tick();
        en = 1'b0; current = '0;
        expect_val("evt_valid_b", K_VALID, 0, 1);
        expect_val("evt_id_b", K_ID, 0, 1);
        tick();
        evt_ready = 1'b1;
        expect_val("evt_valid_c", K_VALID, 0, 1);
        expect_val("evt_id_c", K_ID, 0, 3);
        tick();
        expect_val("evt_valid_d", K_VALID, 0, 0);
        expect_val("evt_ovf", K_OVF, 0, 0);
        tick();

        // overflow: ch0 spikes twice while nothing is accepted
        do_reset("rst_ovf");
        evt_ready = 1'b0; en = 1'b1; set_cur(0, 250);
        for (int s = 0; s < 4; s++) begin
            expect_val($sformatf("ovf_clear%0d", s), K_OVF, 0, 0);
            tick();
        end
        expect_val("ovf_spike2", K_SPIKE, 0, 1);
        expect_val("ovf_set", K_OVF, 0, 1);
        tick();
        en = 1'b0;
        tick();
        expect_val("ovf_sticky", K_OVF, 0, 1);
        expect_val("ovf_valid", K_VALID, 0, 1);
        tick();
        do_reset("rst_ovf_clear");

        // threshold 0 / refract 0 on ch0 only: spike every step, accept and re-arm same edge
        cfg_write(2'd0, 0);
        cfg_write(2'd2, 0);
        cfg_write(2'd3, 1);
        en = 1'b1; evt_ready = 1'b1;
        for (int s = 0; s < 3; s++) begin
            expect_val($sformatf("th0_spike%0d", s), K_SPIKE, 0, 1);
            expect_val($sformatf("th0_valid%0d", s), K_VALID, 0, 1);
            expect_val($sformatf("th0_ovf%0d", s), K_OVF, 0, 0);
            tick();
        end
        en = 1'b0;
        expect_val("th0_drain", K_VALID, 0, 0);
        tick();

        // channel mask and threshold write timing
        do_reset("rst_mask");
        cfg_write(2'd3, 4'b1110);
        en = 1'b1; set_cur(0, 255);
        for (int s = 0; s < 3; s++) begin
            expect_val($sformatf("mask_state%0d", s), K_STATE, 0, 0);
            expect_val($sformatf("mask_spike%0d", s), K_SPIKE, 0, 0);
            tick();
        end
        set_cur(1, 60);
        cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 8'd50;
        expect_val("th_old_state", K_STATE, 1, 60);
        expect_val("th_old_spike", K_SPIKE, 1, 0);
        tick();
        cfg_we = 1'b0;
        expect_val("th_new_spike", K_SPIKE, 1, 1);
        expect_val("th_new_state", K_STATE, 1, 0);
        tick();

        // reset while ch0 refractory counter is 2
        do_reset("rst_refr");
        en = 1'b1; evt_ready = 1'b1; set_cur(0, 250);
        expect_val("refr_spike", K_SPIKE, 0, 1);
        tick();
        tick();
        rst = 1'b1;
        expect_idle("refr_rst");
        tick();
        rst = 1'b0; set_cur(0, 60);
        expect_val("refr_restart", K_STATE, 0, 60);
        expect_val("refr_restart_spk", K_SPIKE, 0, 0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
